// File: rtl/noc_alloc_pkg.sv
// Shared sizing defaults and helpers for the router switch allocator.
package noc_alloc_pkg;

  localparam int P_DEF  = 7;
  localparam int B_DEF  = 4;
  localparam int CW_DEF = B_DEF + 1;

  // Position of the set bit in a one-hot vector; 0 when no bit is set.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (oh[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input queues, the allocator and the crossbar.
interface switch_allocator_if
  import noc_alloc_pkg::*;
#(
  parameter int P = P_DEF
);

  logic [P*P-1:0] req_all;
  logic [P-1:0]   credit_in;
  logic [P*P-1:0] grant_all;
  logic [P*P-1:0] xbar_sel;
  logic [P-1:0]   flit_out_wr;
  logic           credit_err;

  modport master (
    output req_all, credit_in,
    input  grant_all, xbar_sel, flit_out_wr, credit_err
  );

  modport slave (
    input  req_all, credit_in,
    output grant_all, xbar_sel, flit_out_wr, credit_err
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr wins, wrapping N-1 -> 0.
module rr_arbiter
  import noc_alloc_pkg::*;
#(
  parameter int N  = P_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  int unsigned w_idx;

  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = (32'(ptr) + k) % N;
      if (!any_gnt && req[IW'(w_idx)]) begin
        gnt[IW'(w_idx)] = 1'b1;
        any_gnt         = 1'b1;
      end
    end
  end

  assign gnt_idx = IW'(onehot_to_idx(32'(gnt)));

endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with credit-gated eligibility and registered grants.
module switch_allocator
  import noc_alloc_pkg::*;
#(
  parameter int P  = P_DEF,
  parameter int B  = B_DEF,
  parameter int CW = B + 1
) (
  input logic               clk,
  input logic               rst_n,
  switch_allocator_if.slave bus
);

  localparam int            PW   = $clog2(P);
  localparam logic [CW-1:0] FULL = CW'(2 ** B);

  logic [P-1:0]   w_gnt     [P];
  logic [PW-1:0]  w_gnt_idx [P];
  logic [P-1:0]   w_any;
  logic [P-1:0]   w_ovf;
  logic [P*P-1:0] w_grant_all;
  logic [P*P-1:0] w_xbar;

  logic [P*P-1:0] r_grant_all;
  logic [P*P-1:0] r_xbar_sel;
  logic [P-1:0]   r_flit_out_wr;
  logic           r_credit_err;
  logic [CW-1:0]  r_credit [P];
  logic [PW-1:0]  r_ptr    [P];

  for (genvar o = 0; o < P; o++) begin : g_out
    logic [P-1:0] w_col;
    logic         w_has_credit;

    // Gather column o of the request matrix: which inputs want this output.
    for (genvar i = 0; i < P; i++) begin : g_in
      assign w_col[i]              = bus.req_all[i*P+o];
      assign w_grant_all[i*P+o]    = w_gnt[o][i];
      assign w_xbar[o*P+i]         = w_gnt[o][i];
    end

    assign w_has_credit = (r_credit[o] != '0);

    rr_arbiter #(
      .N  (P),
      .IW (PW)
    ) u_arb (
      .req     (w_col & {P{w_has_credit}}),
      .ptr     (r_ptr[o]),
      .gnt     (w_gnt[o]),
      .gnt_idx (w_gnt_idx[o]),
      .any_gnt (w_any[o])
    );

    // A returned credit with no grant on a full counter is an overflow, not a wrap.
    assign w_ovf[o] = bus.credit_in[o] && !w_any[o] && (r_credit[o] == FULL);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_credit[o] <= FULL;
        r_ptr[o]    <= '0;
      end else begin
        if (w_any[o]) begin
          r_ptr[o] <= (w_gnt_idx[o] == PW'(P - 1)) ? '0 : w_gnt_idx[o] + 1'b1;
        end
        unique case ({w_any[o], bus.credit_in[o]})
          2'b10:   r_credit[o] <= r_credit[o] - 1'b1;
          2'b01:   if (!w_ovf[o]) r_credit[o] <= r_credit[o] + 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant_all   <= '0;
      r_xbar_sel    <= '0;
      r_flit_out_wr <= '0;
      r_credit_err  <= 1'b0;
    end else begin
      r_grant_all   <= w_grant_all;
      r_xbar_sel    <= w_xbar;
      r_flit_out_wr <= w_any;
      r_credit_err  <= r_credit_err | (|w_ovf);
    end
  end

  assign bus.grant_all   = r_grant_all;
  assign bus.xbar_sel    = r_xbar_sel;
  assign bus.flit_out_wr = r_flit_out_wr;
  assign bus.credit_err  = r_credit_err;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed and randomized checks of switch_allocator against a queue-free priority-distance model.
module tb_switch_allocator;

  localparam int P    = 7;
  localparam int B    = 4;
  localparam int FULL = 2 ** B;

  logic clk;
  logic rst_n;

  switch_allocator_if #(.P(P)) bus ();

  switch_allocator #(
    .P  (P),
    .B  (B),
    .CW (B + 1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int   m_credit [P];
  int   m_ptr    [P];
  logic m_err;
  logic [P*P-1:0] exp_g;
  logic [P*P-1:0] exp_x;
  logic [P-1:0]   exp_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P*P-1:0] rq(input int i, input int o);
    logic [P*P-1:0] v;
    v = '0;
    v[i*P+o] = 1'b1;
    return v;
  endfunction

  task automatic check_outputs();
    chk("grant_all",   64'(bus.grant_all),   64'(exp_g));
    chk("xbar_sel",    64'(bus.xbar_sel),    64'(exp_x));
    chk("flit_out_wr", 64'(bus.flit_out_wr), 64'(exp_w));
    chk("credit_err",  64'(bus.credit_err),  64'(m_err));
  endtask

  // One cycle: present req/cin, advance the model, then check after the edge.
  task automatic step(input logic [P*P-1:0] req, input logic [P-1:0] cin);
    bus.req_all   = req;
    bus.credit_in = cin;
    exp_g = '0;
    exp_x = '0;
    exp_w = '0;
    for (int o = 0; o < P; o++) begin
      int best;
      int bestd;
      int g;
      best  = -1;
      bestd = P;
      g     = 0;
      if (m_credit[o] > 0) begin
        for (int i = 0; i < P; i++) begin
          if (req[i*P+o]) begin
            int d;
            d = (i - m_ptr[o] + P) % P;
            if (d < bestd) begin
              bestd = d;
              best  = i;
            end
          end
        end
      end
      if (best >= 0) begin
        exp_g[best*P+o] = 1'b1;
        exp_x[o*P+best] = 1'b1;
        exp_w[o]        = 1'b1;
        m_ptr[o]        = (best + 1) % P;
        g               = 1;
      end
      if (cin[o] && g == 0 && m_credit[o] == FULL) m_err = 1'b1;
      else m_credit[o] = m_credit[o] - g + int'(cin[o]);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_all   = '0;
    bus.credit_in = '0;
    @(posedge clk);
    #1;
    for (int o = 0; o < P; o++) begin
      m_credit[o] = FULL;
      m_ptr[o]    = 0;
    end
    m_err = 1'b0;
    exp_g = '0;
    exp_x = '0;
    exp_w = '0;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [P*P-1:0] r;
    logic [P-1:0]   c2;
    logic [6:0]     s;
    c2 = '0;
    c2[2] = 1'b1;

    do_reset();
    step('0, '0);
    // Credit return on a full counter must flag overflow.
    step('0, c2);
    chk("overflow_err", 64'(bus.credit_err), 64'(1));

    do_reset();
    step(rq(3, 5), '0);
    chk("uni_grant", 64'(bus.grant_all), 64'(1) << (3*P+5));
    chk("uni_xbar",  64'(bus.xbar_sel),  64'(1) << (5*P+3));
    chk("uni_wr",    64'(bus.flit_out_wr), 64'(1) << 5);

    r = rq(0, 1) | rq(2, 1) | rq(6, 1);
    step(r, '0);
    s = bus.xbar_sel[1*P +: P];
    chk("rr_1st", 64'(s), 64'(7'h01));
    step(r, '0);
    s = bus.xbar_sel[1*P +: P];
    chk("rr_2nd", 64'(s), 64'(7'h04));
    step(r, '0);
    s = bus.xbar_sel[1*P +: P];
    chk("rr_3rd", 64'(s), 64'(7'h40));
    step(r, '0);
    s = bus.xbar_sel[1*P +: P];
    chk("rr_4th", 64'(s), 64'(7'h01));

    step(rq(4, 0) | rq(4, 3) | rq(4, 6), '0);
    s = bus.grant_all[4*P +: P];
    chk("multicast", 64'(s), 64'(7'b1001001));

    do_reset();
    for (int k = 0; k < FULL; k++) step(rq(0, 2), '0);
    step(rq(0, 2), '0);
    chk("exhaust_blk", 64'(bus.flit_out_wr[2]), 64'(0));
    step(rq(0, 2), c2);
    chk("credit_ret_lat", 64'(bus.flit_out_wr[2]), 64'(0));
    step(rq(0, 2), '0);
    chk("credit_ret_gnt", 64'(bus.flit_out_wr[2]), 64'(1));

    for (int k = 0; k < 5; k++) step('0, c2);
    step(rq(0, 2), c2);
    chk("sim_gnt", 64'(bus.flit_out_wr[2]), 64'(1));
    for (int k = 0; k < 5; k++) step(rq(0, 2), '0);
    step(rq(0, 2), '0);
    chk("sim_credit_hold", 64'(bus.flit_out_wr[2]), 64'(0));

    for (int k = 0; k < 6; k++) step({17'($urandom), 32'($urandom)}, '0);
    do_reset();

    // Heavy demand with sparse returns drives counters toward zero.
    for (int k = 0; k < 200; k++)
      step({17'($urandom), 32'($urandom)} & {17'($urandom), 32'($urandom)},
           7'($urandom) & 7'($urandom) & 7'($urandom) & 7'($urandom));
    for (int k = 0; k < 200; k++)
      step({17'($urandom), 32'($urandom)} & {17'($urandom), 32'($urandom)} &
           {17'($urandom), 32'($urandom)}, 7'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
